// File: rtl/bank_write_arbiter_pkg.sv
// Shared definitions for the spectrogram sample-memory write side.
// Contents:
//   - default widths and depth for the two-bank sample memory
//   - bank-select constants (also used by the readout FSM)
//   - write-side FSM state enum
//   - small helper returning the opposite bank
package bank_write_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 200;
  localparam int DEFAULT_IDX_W  = 8;
  localparam int DEFAULT_CNT_W  = 16;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } wr_state_e;

  function automatic logic other_bank(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/bank_write_arbiter_occupancy.sv
// bank_occupancy: two occupancy flags, one per memory bank.
// A flag is set when its bank is handed to readout and cleared when readout
// releases it. A set and a release of the same bank in one cycle keep the
// bank occupied.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   set_en      - hand the bank selected by set_bank to readout
//   set_bank    - bank being handed over
//   release0/1  - readout finished with bank 0 / bank 1
//   occ         - registered occupancy flags, occ[b] for bank b
module bank_occupancy
  import bank_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic       set_bank,
  input  logic       release0,
  input  logic       release1,
  output logic [1:0] occ
);

  logic [1:0] occ_d;
  logic [1:0] occ_q;

  // Next occupancy: set has priority over release; releasing a free bank is a no-op.
  always_comb begin
    occ_d = occ_q;
    if (set_en && (set_bank == BANK0)) begin
      occ_d[0] = 1'b1;
    end else if (release0) begin
      occ_d[0] = 1'b0;
    end else begin
      occ_d[0] = occ_q[0];
    end
    if (set_en && (set_bank == BANK1)) begin
      occ_d[1] = 1'b1;
    end else if (release1) begin
      occ_d[1] = 1'b0;
    end else begin
      occ_d[1] = occ_q[1];
    end
  end

  // Occupancy flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= 2'b00;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/bank_write_arbiter.sv
// bank_write_arbiter: write-side controller of the ping-pong spectrogram
// sample memory. Streams acquisition samples into the free bank, hands full or
// partially filled banks to the readout FSM and drops samples while both banks
// are occupied.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   ae_active              - acoustic emission in progress (level)
//   sample_valid/data      - one-cycle sample strobe and its value
//   release_bank0/1        - readout finished with a bank (pulse)
//   we, wr_addr, wr_data   - registered memory write port, wr_addr = {bank, idx}
//   bank0_full/bank1_full  - pulse with the write that filled the bank
//   memorization_completed - pulse when an emission ends in a partial bank
//   idx_final              - last index written in that partial bank (held)
//   bank                   - current write bank
//   overflow, drop_cnt     - sticky drop flag and saturating drop counter
//   busy                   - FSM in WRITE or STALL
module bank_write_arbiter
  import bank_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int IDX_W  = DEFAULT_IDX_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ae_active,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              release_bank0,
  input  logic              release_bank1,
  output logic              we,
  output logic [IDX_W:0]    wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              bank0_full,
  output logic              bank1_full,
  output logic              memorization_completed,
  output logic [IDX_W-1:0]  idx_final,
  output logic              bank,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  wr_state_e         state_q, state_d;
  logic              bank_q, bank_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [IDX_W:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              bank0_full_q, bank0_full_d;
  logic              bank1_full_q, bank1_full_d;
  logic              mem_done_q, mem_done_d;
  logic [IDX_W-1:0]  idx_final_q, idx_final_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic       accept_s;
  logic       full_s;
  logic       complete_s;
  logic       drop_s;
  logic [1:0] occ_s;
  logic [1:0] rel_s;
  logic       cur_free_s;
  logic       nxt_free_s;

  assign rel_s = {release_bank1, release_bank0};

  // A bank counts as free if it is unoccupied or being released this cycle,
  // so a release coinciding with a hand-over does not strand the FSM in STALL.
  assign cur_free_s = ~occ_s[bank_q] | rel_s[bank_q];
  assign nxt_free_s = ~occ_s[other_bank(bank_q)] | rel_s[other_bank(bank_q)];

  bank_occupancy u_occ (
    .clk      (clk),
    .reset    (reset),
    .set_en   (full_s | complete_s),
    .set_bank (bank_q),
    .release0 (release_bank0),
    .release1 (release_bank1),
    .occ      (occ_s)
  );

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bank_q       <= BANK0;
      idx_q        <= IDX_ZERO;
      we_q         <= 1'b0;
      wr_addr_q    <= {(IDX_W + 1){1'b0}};
      wr_data_q    <= {DATA_W{1'b0}};
      bank0_full_q <= 1'b0;
      bank1_full_q <= 1'b0;
      mem_done_q   <= 1'b0;
      idx_final_q  <= IDX_ZERO;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      bank0_full_q <= bank0_full_d;
      bank1_full_q <= bank1_full_d;
      mem_done_q   <= mem_done_d;
      idx_final_q  <= idx_final_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state logic plus the per-cycle event strobes that drive the datapath.
  always_comb begin
    state_d    = state_q;
    accept_s   = 1'b0;
    full_s     = 1'b0;
    complete_s = 1'b0;
    drop_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ae_active) begin
          state_d = cur_free_s ? WRITE : STALL;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        // A sample is taken before ae_active is looked at, so a full write
        // coinciding with the end of the emission is processed as full.
        if (sample_valid) begin
          accept_s = 1'b1;
          if (idx_q == IDX_LAST) begin
            full_s  = 1'b1;
            state_d = nxt_free_s ? WRITE : STALL;
          end else begin
            state_d = WRITE;
          end
        end else if (!ae_active) begin
          // idx = 0 here means the bank just switched on a full event.
          complete_s = (idx_q != IDX_ZERO);
          state_d    = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      STALL: begin
        drop_s = sample_valid;
        if (!ae_active) begin
          state_d = IDLE;
        end else if (cur_free_s) begin
          state_d = WRITE;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: write port, bank/index bookkeeping, handshake pulses, drop stats.
  always_comb begin
    bank_d       = bank_q;
    idx_d        = idx_q;
    we_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    bank0_full_d = 1'b0;
    bank1_full_d = 1'b0;
    mem_done_d   = 1'b0;
    idx_final_d  = idx_final_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (accept_s) begin
      we_d      = 1'b1;
      wr_addr_d = {bank_q, idx_q};
      wr_data_d = sample_data;
      if (full_s) begin
        bank0_full_d = (bank_q == BANK0);
        bank1_full_d = (bank_q == BANK1);
        bank_d       = other_bank(bank_q);
        idx_d        = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (complete_s) begin
      mem_done_d  = 1'b1;
      idx_final_d = idx_q - IDX_W'(1);
      bank_d      = other_bank(bank_q);
      idx_d       = IDX_ZERO;
    end else if ((state_q != WRITE) && (state_d == WRITE)) begin
      idx_d = IDX_ZERO;
    end else begin
      idx_d = idx_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Output decode: ports follow the flops, busy is decoded from state.
  always_comb begin
    we                     = we_q;
    wr_addr                = wr_addr_q;
    wr_data                = wr_data_q;
    bank0_full             = bank0_full_q;
    bank1_full             = bank1_full_q;
    memorization_completed = mem_done_q;
    idx_final              = idx_final_q;
    bank                   = bank_q;
    overflow               = overflow_q;
    drop_cnt               = drop_cnt_q;
    case (state_q)
      WRITE:   busy = 1'b1;
      STALL:   busy = 1'b1;
      IDLE:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bank_write_arbiter.sv
module tb_bank_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ae_active = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'h0000;
  logic        release_bank0 = 1'b0;
  logic        release_bank1 = 1'b0;
  logic        we;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        bank0_full;
  logic        bank1_full;
  logic        memorization_completed;
  logic [7:0]  idx_final;
  logic        bank;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int rel_edge = 0;

  logic [8:0]  wq_addr[$];
  logic [15:0] wq_data[$];
  int          wq_cyc[$];
  int          b0_cnt = 0;
  int          b1_cnt = 0;
  int          mc_cnt = 0;
  int          multi_cnt = 0;
  logic [8:0]  b0_addr = 9'h000;
  logic [8:0]  b1_addr = 9'h000;
  logic [7:0]  last_idx_final = 8'h00;

  bank_write_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .ae_active              (ae_active),
    .sample_valid           (sample_valid),
    .sample_data            (sample_data),
    .release_bank0          (release_bank0),
    .release_bank1          (release_bank1),
    .we                     (we),
    .wr_addr                (wr_addr),
    .wr_data                (wr_data),
    .bank0_full             (bank0_full),
    .bank1_full             (bank1_full),
    .memorization_completed (memorization_completed),
    .idx_final              (idx_final),
    .bank                   (bank),
    .overflow               (overflow),
    .drop_cnt               (drop_cnt),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc_cnt);
    end
    if (bank0_full === 1'b1) begin b0_cnt++; b0_addr = wr_addr; end
    if (bank1_full === 1'b1) begin b1_cnt++; b1_addr = wr_addr; end
    if (memorization_completed === 1'b1) begin mc_cnt++; last_idx_final = idx_final; end
    if ((int'(bank0_full === 1'b1) + int'(bank1_full === 1'b1) +
         int'(memorization_completed === 1'b1)) > 1) multi_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    b0_cnt = 0; b1_cnt = 0; mc_cnt = 0; multi_cnt = 0;
    b0_addr = 9'h000; b1_addr = 9'h000; last_idx_final = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; ae_active = 1'b0; sample_valid = 1'b0;
    release_bank0 = 1'b0; release_bank1 = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    clear_log();
  endtask

  // n samples back to back; optional prompt releases, a release pause before
  // sample rel0_at, and ae_active dropped together with the last sample.
  task automatic emit(input int n, input bit prompt, input int rel0_at, input bit ae_with_last);
    bit saw0 = 1'b0;
    bit saw1 = 1'b0;
    ae_active = 1'b1; sample_valid = 1'b0;
    cyc();
    for (int k = 0; k < n; k++) begin
      if (k == rel0_at) begin
        sample_valid = 1'b0; release_bank0 = 1'b1; release_bank1 = 1'b0;
        cyc();
        rel_edge = cyc_cnt;
        release_bank0 = 1'b0;
      end
      sample_valid = 1'b1;
      sample_data = 16'h1000 + 16'(k);
      ae_active = !(ae_with_last && (k == n - 1));
      release_bank0 = prompt && saw0;
      release_bank1 = prompt && saw1;
      cyc();
      saw0 = (bank0_full === 1'b1);
      saw1 = (bank1_full === 1'b1);
    end
    sample_valid = 1'b0; ae_active = 1'b0;
    release_bank0 = prompt && saw0;
    release_bank1 = prompt && saw1;
    cyc();
    release_bank0 = 1'b0; release_bank1 = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_reset();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_checks++; if (wr_addr !== 9'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", wr_addr); end
    n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", wr_data); end
    n_checks++; if ({bank0_full, bank1_full, memorization_completed} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {bank0_full, bank1_full, memorization_completed}); end
    n_checks++; if ({bank, overflow, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_bank_ovf_busy: got %b expected 000", {bank, overflow, busy}); end
    n_checks++; if (drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (idx_final !== 8'h00) begin n_fail++; $display("FAIL reset_idx_final: got %0d expected 0", idx_final); end
    n_checks++; if (dut.occ_s !== 2'b00) begin n_fail++; $display("FAIL reset_occ: got %b expected 00", dut.occ_s); end
  endtask

  task automatic test_short_emission();
    do_reset();
    emit(10, 1'b0, -1, 1'b0);
    n_checks++; if (wq_addr.size() != 10) begin n_fail++; $display("FAIL short_wr_count: got %0d expected 10", wq_addr.size()); end
    for (int j = 0; j < wq_addr.size() && j < 10; j++) begin
      n_checks++; if (wq_addr[j] !== 9'(j)) begin n_fail++; $display("FAIL short_addr[%0d]: got %h expected %h", j, wq_addr[j], 9'(j)); end
      n_checks++; if (wq_data[j] !== 16'h1000 + 16'(j)) begin n_fail++; $display("FAIL short_data[%0d]: got %h expected %h", j, wq_data[j], 16'h1000 + 16'(j)); end
    end
    n_checks++; if (mc_cnt != 1) begin n_fail++; $display("FAIL short_mc_count: got %0d expected 1", mc_cnt); end
    n_checks++; if (last_idx_final !== 8'd9) begin n_fail++; $display("FAIL short_idx_final: got %0d expected 9", last_idx_final); end
    n_checks++; if (idx_final !== 8'd9) begin n_fail++; $display("FAIL short_idx_final_held: got %0d expected 9", idx_final); end
    n_checks++; if (bank !== 1'b1) begin n_fail++; $display("FAIL short_bank: got %b expected 1", bank); end
    n_checks++; if (dut.occ_s !== 2'b01) begin n_fail++; $display("FAIL short_occ: got %b expected 01", dut.occ_s); end
    n_checks++; if ((b0_cnt + b1_cnt) != 0) begin n_fail++; $display("FAIL short_full_pulses: got %0d expected 0", b0_cnt + b1_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_long_emission();
    logic [8:0] ea;
    do_reset();
    emit(450, 1'b1, -1, 1'b0);
    n_checks++; if (wq_addr.size() != 450) begin n_fail++; $display("FAIL long_wr_count: got %0d expected 450", wq_addr.size()); end
    for (int j = 0; j < wq_addr.size() && j < 450; j++) begin
      ea = (j < 200) ? 9'(j) : (j < 400) ? 9'(256 + j - 200) : 9'(j - 400);
      n_checks++; if (wq_addr[j] !== ea) begin n_fail++; $display("FAIL long_addr[%0d]: got %h expected %h", j, wq_addr[j], ea); end
      n_checks++; if (wq_data[j] !== 16'h1000 + 16'(j)) begin n_fail++; $display("FAIL long_data[%0d]: got %h expected %h", j, wq_data[j], 16'h1000 + 16'(j)); end
    end
    n_checks++; if (b0_cnt != 1 || b0_addr !== 9'h0C7) begin n_fail++; $display("FAIL long_bank0_full: got %0d at %h expected 1 at 0c7", b0_cnt, b0_addr); end
    n_checks++; if (b1_cnt != 1 || b1_addr !== 9'h1C7) begin n_fail++; $display("FAIL long_bank1_full: got %0d at %h expected 1 at 1c7", b1_cnt, b1_addr); end
    n_checks++; if (mc_cnt != 1 || last_idx_final !== 8'd49) begin n_fail++; $display("FAIL long_completion: got %0d idx %0d expected 1 idx 49", mc_cnt, last_idx_final); end
    n_checks++; if (multi_cnt != 0) begin n_fail++; $display("FAIL long_exclusive_pulses: got %0d expected 0", multi_cnt); end
    n_checks++; if (bank !== 1'b1 || dut.occ_s !== 2'b01) begin n_fail++; $display("FAIL long_bank_occ: got %b/%b expected 1/01", bank, dut.occ_s); end
    n_checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL long_no_drop: got %b/%0d expected 0/0", overflow, drop_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    emit(450, 1'b0, -1, 1'b0);
    n_checks++; if (wq_addr.size() != 400) begin n_fail++; $display("FAIL ovf_wr_count: got %0d expected 400", wq_addr.size()); end
    n_checks++; if (b0_cnt != 1 || b1_cnt != 1) begin n_fail++; $display("FAIL ovf_full_counts: got %0d/%0d expected 1/1", b0_cnt, b1_cnt); end
    n_checks++; if (drop_cnt !== 16'd50) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 50", drop_cnt); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_checks++; if (mc_cnt != 0) begin n_fail++; $display("FAIL ovf_no_completion: got %0d expected 0", mc_cnt); end
    n_checks++; if (bank !== 1'b0 || dut.occ_s !== 2'b11) begin n_fail++; $display("FAIL ovf_bank_occ: got %b/%b expected 0/11", bank, dut.occ_s); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_stall_recovery();
    do_reset();
    emit(450, 1'b0, 410, 1'b0);
    n_checks++; if (drop_cnt !== 16'd10) begin n_fail++; $display("FAIL rec_drop_cnt: got %0d expected 10", drop_cnt); end
    n_checks++; if (wq_addr.size() != 440) begin n_fail++; $display("FAIL rec_wr_count: got %0d expected 440", wq_addr.size()); end
    if (wq_addr.size() > 400) begin
      n_checks++; if (wq_addr[400] !== 9'h000) begin n_fail++; $display("FAIL rec_resume_addr: got %h expected 000", wq_addr[400]); end
      n_checks++; if (wq_cyc[400] != rel_edge + 1) begin n_fail++; $display("FAIL rec_resume_cycle: got %0d expected %0d", wq_cyc[400], rel_edge + 1); end
      n_checks++; if (wq_data[400] !== 16'h1000 + 16'd410) begin n_fail++; $display("FAIL rec_resume_data: got %h expected %h", wq_data[400], 16'h1000 + 16'd410); end
    end
    n_checks++; if (mc_cnt != 1 || last_idx_final !== 8'd39) begin n_fail++; $display("FAIL rec_completion: got %0d idx %0d expected 1 idx 39", mc_cnt, last_idx_final); end
    n_checks++; if (dut.occ_s !== 2'b11) begin n_fail++; $display("FAIL rec_occ: got %b expected 11", dut.occ_s); end
  endtask

  task automatic test_ae_falls_on_full();
    do_reset();
    emit(200, 1'b0, -1, 1'b1);
    n_checks++; if (wq_addr.size() != 200) begin n_fail++; $display("FAIL aefall_wr_count: got %0d expected 200", wq_addr.size()); end
    n_checks++; if (b0_cnt != 1 || b0_addr !== 9'h0C7) begin n_fail++; $display("FAIL aefall_bank0_full: got %0d at %h expected 1 at 0c7", b0_cnt, b0_addr); end
    n_checks++; if (mc_cnt != 0 || b1_cnt != 0) begin n_fail++; $display("FAIL aefall_no_other_pulse: got mc %0d b1 %0d expected 0 0", mc_cnt, b1_cnt); end
    n_checks++; if (bank !== 1'b1 || dut.occ_s !== 2'b01) begin n_fail++; $display("FAIL aefall_bank_occ: got %b/%b expected 1/01", bank, dut.occ_s); end
  endtask

  task automatic test_release_free_bank();
    do_reset();
    emit(10, 1'b0, -1, 1'b0);
    release_bank1 = 1'b1; cyc(); release_bank1 = 1'b0; cyc();
    n_checks++; if (dut.occ_s !== 2'b01) begin n_fail++; $display("FAIL relfree_occ: got %b expected 01", dut.occ_s); end
    release_bank0 = 1'b1; cyc(); release_bank0 = 1'b0; cyc();
    n_checks++; if (dut.occ_s !== 2'b00) begin n_fail++; $display("FAIL relbusy_occ: got %b expected 00", dut.occ_s); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    emit(10, 1'b0, -1, 1'b0);
    ae_active = 1'b1; cyc();
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1; sample_data = 16'hBEE0 + 16'(k); cyc();
    end
    n_checks++; if (busy !== 1'b1 || we !== 1'b1 || wr_addr !== 9'h104) begin n_fail++; $display("FAIL midwr_before: got busy %b we %b addr %h expected 1 1 104", busy, we, wr_addr); end
    reset = 1'b1; sample_valid = 1'b1; cyc();
    n_checks++; if ({we, bank0_full, bank1_full, memorization_completed, bank, overflow, busy} !== 7'b0) begin n_fail++; $display("FAIL midwr_flags: got %b expected 0000000", {we, bank0_full, bank1_full, memorization_completed, bank, overflow, busy}); end
    n_checks++; if (wr_addr !== 9'h000 || wr_data !== 16'h0000 || idx_final !== 8'h00 || drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL midwr_values: got %h %h %h %h expected all 0", wr_addr, wr_data, idx_final, drop_cnt); end
    n_checks++; if (dut.occ_s !== 2'b00) begin n_fail++; $display("FAIL midwr_occ: got %b expected 00", dut.occ_s); end
    reset = 1'b0; sample_valid = 1'b0; ae_active = 1'b0; cyc();
  endtask

  initial begin
    reset = 1'b1;
    cyc(); cyc();
    test_reset();
    test_short_emission();
    test_long_emission();
    test_overflow();
    test_stall_recovery();
    test_ae_falls_on_full();
    test_release_free_bank();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
